cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Shares the single common data bus (CDB) between two result producers: ALU (req 0) and load/store
//   unit (req 1). Each requester hands results over with valid/ready into a one-entry holding register.
//   A round-robin arbiter picks one pending entry per cycle and drives the registered CDB broadcast
//   consumed by the ROB and reservation stations. Flush discards all in-flight results.
// PARAMETERS
//   NAME_W   5   width of register name field (`NameBus); name 0 == nameFree
//   TAG_W    4   width of ROB tag field (`TagBus); tag 0 == tagFree
//   DATA_W   32  width of result data (`DataBus)
// PORTS
//   clk            in   1       single clock, rising edge
//   rst            in   1       asynchronous reset, active-low (0 = reset)
//   flush          in   1       sync discard of all pending/unsent results
//   alu_valid      in   1       ALU result offered
//   alu_ready      out  1       ALU result accepted when alu_valid & alu_ready
//   alu_name       in   NAME_W  destination name
//   alu_tag        in   TAG_W   ROB tag
//   alu_data       in   DATA_W  result
//   ls_valid       in   1       LS result offered
//   ls_ready       out  1       LS result accepted when ls_valid & ls_ready
//   ls_name        in   NAME_W  destination name
//   ls_tag         in   TAG_W   ROB tag
//   ls_data        in   DATA_W  result
//   enCDBWrt       out  1       CDB broadcast valid this cycle
//   CDBwrtName     out  NAME_W  broadcast name
//   CDBwrtTag      out  TAG_W   broadcast tag
//   CDBwrtData     out  DATA_W  broadcast data
// BEHAVIOUR
//   - Reset (rst==0, async): enCDBWrt=0, CDBwrtName=0, CDBwrtTag=0, CDBwrtData=0; both holding regs
//     empty (pend0=pend1=0); round-robin pointer last_gnt=1 (so ALU wins first tie). Reset mid-transfer
//     drops everything; no partial broadcast after release.
//   - State: pend0/pend1 + payload regs, last_gnt (1 bit), CDB output regs. No other FSM.
//   - Grant (comb, from registered state only): gnt0 = pend0 & (!pend1 | last_gnt==1);
//     gnt1 = pend1 & (!pend0 | last_gnt==0). At most one grant; none when flush=1.
//   - ready (comb, independent of valid): alu_ready = !flush & (!pend0 | gnt0); ls_ready likewise.
//     Sustains one accept per requester per cycle when granted every cycle (no bubble).
//   - Accept edge: payload loaded into holding reg, pend set. Granted and not refilled: pend cleared.
//     Granted and refilled same cycle: pend stays 1 with new payload.
//   - Output edge: if a grant, CDB regs <= granted payload, enCDBWrt<=1, last_gnt<=granted index;
//     else enCDBWrt<=0, name/tag/data <= 0 (free values). Outputs are pure registers.
//   - Latency: accept in cycle N -> broadcast visible cycle N+1 if granted in N+1 -> earliest N+2 on CDB
//     counting from acceptance edge; i.e. valid sampled at edge E appears on CDB after edge E+1.
//   - Contention: both pending -> alternate strictly; a requester waits at most 1 grant. Single
//     pending requester is granted every cycle regardless of last_gnt.
//   - Payload pass-through: name/tag/data broadcast bit-exact; name==0 is still broadcast (no filter).
//   - flush=1 at edge: pend0=pend1=0, no accept, no grant, enCDBWrt<=0 with zeroed fields. Output
//     already on CDB during the flush cycle is not recalled.
//   - Holding payload regs hold value when not loading; contents irrelevant while pend=0.
// TESTING
//   1 Reset: rst=0 with valids high -> all outputs 0, ready low; after rst=1 first cycle ready=1, CDB idle.
//   2 Single ALU: alu name=3 tag=2 data=0xDEADBEEF one cycle -> exactly one enCDBWrt pulse 2 edges later
//     with 3/2/0xDEADBEEF, then enCDBWrt=0 and fields 0.
//   3 Contention: both valid every cycle, ALU data 1,2,3.., LS data 100,101.. -> CDB order 1,100,2,101,..
//     ready toggles so each side accepts every other cycle; no loss/duplicate over 64 results.
//   4 Streaming: only LS valid 16 back-to-back cycles -> ls_ready stays 1, 16 consecutive CDB pulses.
//   5 Flush: both pending, flush=1 one cycle -> ready=0 that cycle, no broadcast of the pending pair,
//     next accepted result broadcast normally; ALU wins first post-flush tie iff last_gnt=1.
//   6 Async reset mid-stream: drop rst between edges -> outputs 0 immediately, nothing replayed after.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two one-entry holding registers (ALU, LS)
// drained round-robin onto a registered CDB broadcast.
module cdb_arbiter #(
    parameter int NAME_W = 5,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [NAME_W-1:0] alu_name,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic [NAME_W-1:0] ls_name,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [DATA_W-1:0] ls_data,
    output logic              enCDBWrt,
    output logic [NAME_W-1:0] CDBwrtName,
    output logic [TAG_W-1:0]  CDBwrtTag,
    output logic [DATA_W-1:0] CDBwrtData
);

    typedef struct packed {
        logic [NAME_W-1:0] name;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } res_t;

    res_t hold0_q, hold0_d;
    res_t hold1_q, hold1_d;
    res_t cdb_q, cdb_d;
    logic pend0_q, pend0_d;
    logic pend1_q, pend1_d;
    logic last_gnt_q, last_gnt_d;
    logic en_q, en_d;
    logic gnt0, gnt1, acc0, acc1;

    always_comb begin
        gnt0 = !flush && pend0_q && (!pend1_q || last_gnt_q);
        gnt1 = !flush && pend1_q && (!pend0_q || !last_gnt_q);

        // A slot being drained this cycle can be refilled on the same edge
        alu_ready = rst && !flush && (!pend0_q || gnt0);
        ls_ready  = rst && !flush && (!pend1_q || gnt1);
        acc0 = alu_valid && alu_ready;
        acc1 = ls_valid && ls_ready;

        pend0_d = acc0 || (pend0_q && !gnt0 && !flush);
        pend1_d = acc1 || (pend1_q && !gnt1 && !flush);
        hold0_d = acc0 ? res_t'({alu_name, alu_tag, alu_data}) : hold0_q;
        hold1_d = acc1 ? res_t'({ls_name, ls_tag, ls_data}) : hold1_q;

        en_d       = gnt0 || gnt1;
        cdb_d      = '0;
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            cdb_d      = hold0_q;
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            cdb_d      = hold1_q;
            last_gnt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            last_gnt_q <= 1'b1;
            en_q       <= 1'b0;
            cdb_q      <= '0;
        end else begin
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
            last_gnt_q <= last_gnt_d;
            en_q       <= en_d;
            cdb_q      <= cdb_d;
        end
    end

    assign enCDBWrt   = en_q;
    assign CDBwrtName = cdb_q.name;
    assign CDBwrtTag  = cdb_q.tag;
    assign CDBwrtData = cdb_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: queue-based reference model of the two
// holding slots with round-robin draining, plus directed scenarios.
module tb_cdb_arbiter;
    localparam int NW = 5;
    localparam int TW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [NW-1:0] n;
        logic [TW-1:0] t;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic alu_valid = 1'b0, ls_valid = 1'b0;
    logic alu_ready, ls_ready;
    logic [NW-1:0] alu_name = '0, ls_name = '0;
    logic [TW-1:0] alu_tag = '0, ls_tag = '0;
    logic [DW-1:0] alu_data = '0, ls_data = '0;
    logic enCDBWrt;
    logic [NW-1:0] CDBwrtName;
    logic [TW-1:0] CDBwrtTag;
    logic [DW-1:0] CDBwrtData;

    int passed = 0;
    int total = 0;

    ent_t q0[$];
    ent_t q1[$];
    int   lg = 1;
    logic exp_en = 1'b0;
    ent_t exp_out = '0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_name(alu_name), .alu_tag(alu_tag), .alu_data(alu_data),
        .ls_valid(ls_valid), .ls_ready(ls_ready),
        .ls_name(ls_name), .ls_tag(ls_tag), .ls_data(ls_data),
        .enCDBWrt(enCDBWrt), .CDBwrtName(CDBwrtName),
        .CDBwrtTag(CDBwrtTag), .CDBwrtData(CDBwrtData)
    );

    // Which held result goes out this cycle: -1 none, 0 ALU, 1 LS
    function automatic int pick();
        if (!rst || flush) return -1;
        if (q0.size() > 0 && q1.size() > 0) return (lg == 1) ? 0 : 1;
        if (q0.size() > 0) return 0;
        if (q1.size() > 0) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] model_rdy();
        int w;
        logic r0, r1;
        w = pick();
        r0 = rst && !flush && (q0.size() == 0 || w == 0);
        r1 = rst && !flush && (q1.size() == 0 || w == 1);
        return {r0, r1};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        lg = 1;
        exp_en = 1'b0;
        exp_out = '0;
    endtask

    task automatic model_edge();
        int w;
        logic [1:0] r;
        if (!rst) begin
            model_reset();
            return;
        end
        w = pick();
        r = model_rdy();
        if (flush) begin
            q0.delete();
            q1.delete();
            exp_en = 1'b0;
            exp_out = '0;
            return;
        end
        if (w == 0) begin
            exp_out = q0.pop_front();
            exp_en = 1'b1;
            lg = 0;
        end else if (w == 1) begin
            exp_out = q1.pop_front();
            exp_en = 1'b1;
            lg = 1;
        end else begin
            exp_en = 1'b0;
            exp_out = '0;
        end
        if (alu_valid && r[1]) q0.push_back(ent_t'({alu_name, alu_tag, alu_data}));
        if (ls_valid && r[0]) q1.push_back(ent_t'({ls_name, ls_tag, ls_data}));
    endtask

    // Samples ready mid-cycle, advances one edge, leaves time at edge+1
    task automatic cycle(output logic [1:0] ra, output logic [1:0] re);
        #1;
        ra = {alu_ready, ls_ready};
        re = model_rdy();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_inputs(input int pa, input int pl);
        alu_valid = ($urandom_range(99) < pa);
        ls_valid = ($urandom_range(99) < pl);
        alu_name = NW'($urandom);
        alu_tag = TW'($urandom);
        alu_data = $urandom;
        ls_name = NW'($urandom);
        ls_tag = TW'($urandom);
        ls_data = $urandom;
    endtask

    task automatic test_reset();
        logic [1:0] ra, re;
        #1 rst = 1'b0;
        alu_valid = 1'b1;
        ls_valid = 1'b1;
        #2;
        total++;
        if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData} !== '0)
            $display("FAIL reset_out: got %b/%h/%h/%h required all zero",
                     enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData);
        else passed++;
        total++;
        if ({alu_ready, ls_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b required 00", {alu_ready, ls_ready});
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({enCDBWrt, CDBwrtData} !== '0)
            $display("FAIL reset_hold: got %b/%h required 0", enCDBWrt, CDBwrtData);
        else passed++;
        model_reset();
        alu_valid = 1'b0;
        ls_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({alu_ready, ls_ready} !== 2'b11)
            $display("FAIL release_ready: got %b required 11", {alu_ready, ls_ready});
        else passed++;
        cycle(ra, re);
        total++;
        if (enCDBWrt !== 1'b0)
            $display("FAIL release_idle: got en=%b required 0", enCDBWrt);
        else passed++;
    endtask

    task automatic test_single_alu();
        logic [1:0] ra, re;
        alu_valid = 1'b1;
        alu_name = 5'd3;
        alu_tag = 4'd2;
        alu_data = 32'hDEADBEEF;
        cycle(ra, re);
        alu_valid = 1'b0;
        total++;
        if (enCDBWrt !== 1'b0)
            $display("FAIL single_early: got en=%b required 0", enCDBWrt);
        else passed++;
        cycle(ra, re);
        total++;
        if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData} !== {1'b1, 5'd3, 4'd2, 32'hDEADBEEF})
            $display("FAIL single_bcast: got %b/%0d/%0d/%h required 1/3/2/deadbeef",
                     enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData);
        else passed++;
        cycle(ra, re);
        total++;
        if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData} !== '0)
            $display("FAIL single_after: got %b/%0d/%0d/%h required all zero",
                     enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData);
        else passed++;
    endtask

    task automatic test_contention();
        logic [1:0] ra, re;
        int ad, ld, cyc;
        logic [DW-1:0] got[$];
        logic [DW-1:0] want;
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        ad = 1;
        ld = 100;
        alu_valid = 1'b1;
        ls_valid = 1'b1;
        cyc = 0;
        while (got.size() < 64 && cyc < 200) begin
            alu_name = NW'(ad);
            alu_tag = TW'(ad);
            alu_data = DW'(ad);
            ls_name = NW'(ld);
            ls_tag = TW'(ld);
            ls_data = DW'(ld);
            cycle(ra, re);
            if (re[1]) ad++;
            if (re[0]) ld++;
            cyc++;
            total++;
            if (ra !== re)
                $display("FAIL cont_ready: cycle %0d got %b required %b", cyc, ra, re);
            else passed++;
            total++;
            if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData} !== {exp_en, exp_out})
                $display("FAIL cont_cdb: cycle %0d got %b/%h required %b/%h",
                         cyc, enCDBWrt, CDBwrtData, exp_en, exp_out.d);
            else passed++;
            if (enCDBWrt === 1'b1) got.push_back(CDBwrtData);
        end
        total++;
        if (got.size() < 64)
            $display("FAIL cont_timeout: got %0d results required 64", got.size());
        else passed++;
        for (int i = 0; i < 64 && i < got.size(); i++) begin
            want = (i % 2 == 0) ? DW'(1 + i / 2) : DW'(100 + i / 2);
            total++;
            if (got[i] !== want)
                $display("FAIL cont_order: idx %0d got %0d required %0d", i, got[i], want);
            else passed++;
        end
        alu_valid = 1'b0;
        ls_valid = 1'b0;
        repeat (3) cycle(ra, re);
    endtask

    task automatic test_streaming();
        logic [1:0] ra, re;
        int pulses, first, last;
        pulses = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 21; i++) begin
            ls_valid = (i < 16);
            ls_data = DW'(500 + i);
            ls_name = NW'(i);
            ls_tag = TW'(i);
            cycle(ra, re);
            if (i < 16) begin
                total++;
                if (ra[0] !== 1'b1)
                    $display("FAIL stream_ready: cycle %0d got %b required 1", i, ra[0]);
                else passed++;
            end
            if (enCDBWrt === 1'b1) begin
                total++;
                if (CDBwrtData !== DW'(500 + pulses))
                    $display("FAIL stream_data: got %0d required %0d", CDBwrtData, 500 + pulses);
                else passed++;
                if (first < 0) first = i;
                last = i;
                pulses++;
            end
        end
        ls_valid = 1'b0;
        total++;
        if (pulses !== 16 || first !== 1 || last !== 16)
            $display("FAIL stream_pulses: got %0d pulses at %0d..%0d required 16 at 1..16",
                     pulses, first, last);
        else passed++;
    endtask

    task automatic test_flush();
        logic [1:0] ra, re;
        logic [DW-1:0] first_want, second_want;
        alu_valid = 1'b1;
        ls_valid = 1'b1;
        alu_data = 32'hA0A0_0001;
        ls_data = 32'hB0B0_0001;
        cycle(ra, re);
        flush = 1'b1;
        alu_data = 32'hA0A0_0002;
        ls_data = 32'hB0B0_0002;
        cycle(ra, re);
        total++;
        if (ra !== 2'b00)
            $display("FAIL flush_ready: got %b required 00", ra);
        else passed++;
        total++;
        if ({enCDBWrt, CDBwrtData} !== '0)
            $display("FAIL flush_cdb: got %b/%h required 0", enCDBWrt, CDBwrtData);
        else passed++;
        flush = 1'b0;
        alu_valid = 1'b0;
        ls_valid = 1'b0;
        cycle(ra, re);
        total++;
        if (enCDBWrt !== 1'b0)
            $display("FAIL flush_discard: got en=%b required 0", enCDBWrt);
        else passed++;
        alu_valid = 1'b1;
        ls_valid = 1'b1;
        alu_data = 32'hA0A0_0003;
        ls_data = 32'hB0B0_0003;
        first_want = (lg == 1) ? alu_data : ls_data;
        second_want = (lg == 1) ? ls_data : alu_data;
        cycle(ra, re);
        alu_valid = 1'b0;
        ls_valid = 1'b0;
        cycle(ra, re);
        total++;
        if (enCDBWrt !== 1'b1 || CDBwrtData !== first_want)
            $display("FAIL flush_tie1: got %b/%h required 1/%h", enCDBWrt, CDBwrtData, first_want);
        else passed++;
        cycle(ra, re);
        total++;
        if (enCDBWrt !== 1'b1 || CDBwrtData !== second_want)
            $display("FAIL flush_tie2: got %b/%h required 1/%h", enCDBWrt, CDBwrtData, second_want);
        else passed++;
        cycle(ra, re);
    endtask

    task automatic test_async_reset();
        logic [1:0] ra, re;
        for (int i = 0; i < 10; i++) begin
            rand_inputs(80, 80);
            cycle(ra, re);
            total++;
            if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData} !== {exp_en, exp_out})
                $display("FAIL arst_pre: cycle %0d got %b/%h required %b/%h",
                         i, enCDBWrt, CDBwrtData, exp_en, exp_out.d);
            else passed++;
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        total++;
        if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData, alu_ready, ls_ready} !== '0)
            $display("FAIL arst_now: got en=%b data=%h rdy=%b required all zero",
                     enCDBWrt, CDBwrtData, {alu_ready, ls_ready});
        else passed++;
        cycle(ra, re);
        alu_valid = 1'b0;
        ls_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(ra, re);
            total++;
            if (enCDBWrt !== 1'b0)
                $display("FAIL arst_replay: cycle %0d got en=%b data=%h required 0",
                         i, enCDBWrt, CDBwrtData);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [1:0] ra, re;
        for (int i = 0; i < 400; i++) begin
            rand_inputs(70, 60);
            flush = ($urandom_range(19) == 0);
            cycle(ra, re);
            total++;
            if (ra !== re)
                $display("FAIL rand_ready: cycle %0d got %b required %b", i, ra, re);
            else passed++;
            total++;
            if ({enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData} !== {exp_en, exp_out})
                $display("FAIL rand_cdb: cycle %0d got %b/%0d/%0d/%h required %b/%0d/%0d/%h",
                         i, enCDBWrt, CDBwrtName, CDBwrtTag, CDBwrtData,
                         exp_en, exp_out.n, exp_out.t, exp_out.d);
            else passed++;
        end
        flush = 1'b0;
        alu_valid = 1'b0;
        ls_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_streaming();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
